pwm_duty_meter: RTL and testbench
=================================

Name: pwm_duty_meter

Overview:
- Dual-channel PWM receiver: measures the duty cycle of two incoming PWM lines over a fixed window of 2^C_WINDOW_LOG2 clocks and reports each as a C_PWM_WIDTH-bit fraction.
- Uses the same value scaling as the PWM generators in this codebase, so a measured value can be compared directly with a loaded setpoint.
- Also reports the rising-edge count per window and stuck-high/stuck-low status.
- Used for loopback self-test of the PWM outputs and for monitoring external PWM sources.

Parameters:
- C_PWM_WIDTH, 24, width of reported duty value (1..24).
- C_WINDOW_LOG2, 16, log2 of measurement window length in clocks (4..24).
- C_EDGE_WIDTH, 16, width of per-channel rising-edge counter.

Ports:
- pwm_clk_i  input  1  measurement clock.
- pwm_rst_n_i  input  1  asynchronous active-low reset.
- enable_i  input  1  measurement enable, synchronous to pwm_clk_i.
- PWM  input  2  PWM lines, asynchronous to pwm_clk_i.
- duty0_o  output  C_PWM_WIDTH  channel 0 duty, held between windows.
- duty1_o  output  C_PWM_WIDTH  channel 1 duty, held between windows.
- edges0_o  output  C_EDGE_WIDTH  channel 0 rising edges in last window (saturating).
- edges1_o  output  C_EDGE_WIDTH  channel 1 rising edges in last window (saturating).
- stuck_o  output  4  {ch1 high, ch1 low, ch0 high, ch0 low}: no edges in last window, line at the stated level.
- duty_valid_o  output  1  one-cycle pulse when all result outputs update.

Behaviour:
- Reset is asynchronous on pwm_rst_n_i low. Released via an internal 2-FF reset synchronizer, so deassertion is synchronous.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - window counter wc = 0;
  - high counters hc[k] = 0;
  - edge counters ec[k] = 0;
  - synchronizer and previous-sample registers = 0.
- Input synchronizer:
  - each PWM bit passes through 2 flops, giving s[k];
  - a 3rd flop holds p[k] for edge detection;
  - a rising edge is s[k] & ~p[k];
  - input-to-count latency is 2 clocks.
- State machine IDLE -> MEASURE:
  - IDLE: counters held at 0; results hold their last values. Goes to MEASURE on the cycle enable_i=1 is sampled.
  - MEASURE: each cycle, wc increments; hc[k] increments if s[k]=1; ec[k] increments on a rising edge, saturating at 2^C_EDGE_WIDTH-1.
  - MEASURE on wc = 2^C_WINDOW_LOG2-1:
    - window end: final counts include the current cycle's sample and edge;
    - results are latched, duty_valid_o =1 for the next cycle only;
    - wc, hc and ec wrap to 0 and the next window starts with no gap.
  - MEASURE with enable_i=0 sampled: go to IDLE and clear the counters. The partial window is discarded: no duty_valid_o and no result update.
- Duty scaling:
  - W = 2^C_WINDOW_LOG2; the final high count n lies in 0..W.
  - n = W gives all ones (saturate).
  - Otherwise, if C_WINDOW_LOG2 >= C_PWM_WIDTH: duty = n[C_WINDOW_LOG2-1 -: C_PWM_WIDTH].
  - Otherwise: duty = n << (C_PWM_WIDTH - C_WINDOW_LOG2).
- Stuck flags: updated at window end.
  - Low flag set iff final edges = 0 and n = 0.
  - High flag set iff final edges = 0 and n = W.
  - Both flags 0 otherwise. A single falling edge with no rising edge clears both.
- Edges: a rising edge on the first sample of a window is counted if p (from the previous window's last cycle) was 0. p is never reset between windows.
- Simultaneous window end and enable_i falling: the window completes and results publish, then the block enters IDLE.
- Reset mid-window: everything returns immediately to its reset value; no pulse is issued.

Test Plan:
All scenarios use C_WINDOW_LOG2=8, C_PWM_WIDTH=24, C_EDGE_WIDTH=16.
- PWM=2'b01 held, enable_i=1 for 600 clocks -> pulses at windows 1 and 2; duty0_o=24'hFF_FF_FF, duty1_o=0; stuck_o=4'b0110; edges both 0 (after the first window).
- Ch0 square wave, period 4 (2 high / 2 low), phase-locked -> duty0_o=24'h80_00_00, edges0_o=64, stuck_o[1:0]=0.
- Ch1 period 8, 1 high -> duty1_o=24'h20_00_00, edges1_o=32.
- Drop enable_i at wc=100, re-raise 10 clocks later -> no duty_valid_o for the partial window; next pulse exactly 256 clocks (+ sync latency) after re-enable; prior results held throughout.
- Assert pwm_rst_n_i low for 1 clock mid-window with outputs nonzero -> all outputs 0 asynchronously; after release, measurement restarts from wc=0.
- Ch0 toggling every clock -> edges0_o=128, duty0_o=24'h80_00_00; edge counter verified not to saturate. A separate build with C_EDGE_WIDTH=4 gives edges0_o=15.

Source files
------------

// File: rtl/pwm_duty_meter.sv
// Dual-channel PWM duty meter.
// Measures the high time and rising-edge count of two asynchronous PWM lines
// over a window of 2^C_WINDOW_LOG2 clocks. The duty result uses the same
// scaling as the PWM generators, so it can be compared directly with a setpoint.
// Stuck-high and stuck-low status is reported for each channel.
module pwm_duty_meter #(
  parameter int C_PWM_WIDTH   = 24,
  parameter int C_WINDOW_LOG2 = 16,
  parameter int C_EDGE_WIDTH  = 16
) (
  input  logic                    pwm_clk_i,
  input  logic                    pwm_rst_n_i,
  input  logic                    enable_i,
  input  logic [1:0]              PWM,
  output logic [C_PWM_WIDTH-1:0]  duty0_o,
  output logic [C_PWM_WIDTH-1:0]  duty1_o,
  output logic [C_EDGE_WIDTH-1:0] edges0_o,
  output logic [C_EDGE_WIDTH-1:0] edges1_o,
  output logic [3:0]              stuck_o,
  output logic                    duty_valid_o
);

  localparam logic [C_WINDOW_LOG2-1:0] WC_LAST = '1;
  localparam logic [C_WINDOW_LOG2-1:0] WC_ONE  = 1;
  localparam logic [C_EDGE_WIDTH-1:0]  EC_MAX  = '1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assertion is immediate, release is aligned to the clock.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  // Two-flop reset release chain, cleared asynchronously by the external reset.
  always_ff @(posedge pwm_clk_i or negedge pwm_rst_n_i) begin
    if (!pwm_rst_n_i) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detector.
  // s_reg is the sampled level used for counting; p_reg is its previous value.
  // p_reg keeps running across window boundaries so an edge on the first
  // sample of a window is still detected.
  // ---------------------------------------------------------------------------
  logic [1:0] meta_reg;
  logic [1:0] s_reg;
  logic [1:0] p_reg;
  logic [1:0] rise;

  // Two synchronizing flops per line plus one history flop for edge detection.
  always_ff @(posedge pwm_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 2'b00;
      s_reg    <= 2'b00;
      p_reg    <= 2'b00;
    end else begin
      meta_reg <= PWM;
      s_reg    <= meta_reg;
      p_reg    <= s_reg;
    end
  end

  assign rise = s_reg & ~p_reg;

  // ---------------------------------------------------------------------------
  // Control state machine and window counter.
  // ---------------------------------------------------------------------------
  state_t                   state_reg;
  state_t                   state_next;
  logic [C_WINDOW_LOG2-1:0] wc_reg;
  logic                     window_end;
  logic                     count_run;
  logic                     valid_reg;

  // State register.
  always_ff @(posedge pwm_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, window-end detect and counter run/clear decision.
  always_comb begin
    state_next = state_reg;
    window_end = 1'b0;
    count_run  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable_i) begin
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // The last cycle of a window always completes, even if enable drops.
        window_end = (wc_reg == WC_LAST);
        // Counters keep accumulating only mid-window with enable held;
        // otherwise they wrap (window end) or are discarded (enable low).
        count_run  = enable_i && !window_end;
        if (!enable_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Window counter: runs while measuring, returns to 0 at window end or stop.
  always_ff @(posedge pwm_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wc_reg <= '0;
    end else if (count_run) begin
      wc_reg <= wc_reg + WC_ONE;
    end else begin
      wc_reg <= '0;
    end
  end

  // Result-valid strobe, high for the cycle after a window completes.
  always_ff @(posedge pwm_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= window_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel accumulation and result registers.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [C_WINDOW_LOG2:0]   hc_reg;
      logic [C_EDGE_WIDTH-1:0]  ec_reg;
      logic [C_WINDOW_LOG2:0]   n_final;
      logic [C_EDGE_WIDTH-1:0]  e_final;
      logic [C_PWM_WIDTH-1:0]   duty_scaled;
      logic [C_PWM_WIDTH-1:0]   duty_calc;
      logic                     stuck_lo;
      logic                     stuck_hi;
      logic [C_PWM_WIDTH-1:0]   duty_reg;
      logic [C_EDGE_WIDTH-1:0]  edges_reg;
      logic [1:0]               stuck_reg;

      // Counts including the current cycle, so the window-end sample is kept.
      assign n_final = hc_reg + (C_WINDOW_LOG2 + 1)'(s_reg[gi]);
      assign e_final = (ec_reg == EC_MAX) ? EC_MAX
                                          : ec_reg + C_EDGE_WIDTH'(rise[gi]);

      // Align the high count to the generator's fixed-point duty format.
      if (C_WINDOW_LOG2 >= C_PWM_WIDTH) begin : g_trunc
        assign duty_scaled = n_final[C_WINDOW_LOG2-1 -: C_PWM_WIDTH];
      end else begin : g_shift
        assign duty_scaled = {n_final[C_WINDOW_LOG2-1:0],
                              {(C_PWM_WIDTH - C_WINDOW_LOG2){1'b0}}};
      end

      // A full window of high samples has the top bit set; report all ones.
      assign duty_calc = n_final[C_WINDOW_LOG2] ? '1 : duty_scaled;
      assign stuck_lo  = (e_final == '0) && (n_final == '0);
      assign stuck_hi  = (e_final == '0) && n_final[C_WINDOW_LOG2];

      // High-time and rising-edge accumulators.
      always_ff @(posedge pwm_clk_i or negedge rst_n) begin
        if (!rst_n) begin
          hc_reg <= '0;
          ec_reg <= '0;
        end else if (count_run) begin
          hc_reg <= n_final;
          ec_reg <= e_final;
        end else begin
          hc_reg <= '0;
          ec_reg <= '0;
        end
      end

      // Results latched at window end and held until the next completed window.
      always_ff @(posedge pwm_clk_i or negedge rst_n) begin
        if (!rst_n) begin
          duty_reg  <= '0;
          edges_reg <= '0;
          stuck_reg <= 2'b00;
        end else if (window_end) begin
          duty_reg  <= duty_calc;
          edges_reg <= e_final;
          stuck_reg <= {stuck_hi, stuck_lo};
        end
      end
    end
  endgenerate

  assign duty0_o      = g_ch[0].duty_reg;
  assign duty1_o      = g_ch[1].duty_reg;
  assign edges0_o     = g_ch[0].edges_reg;
  assign edges1_o     = g_ch[1].edges_reg;
  assign stuck_o      = {g_ch[1].stuck_reg, g_ch[0].stuck_reg};
  assign duty_valid_o = valid_reg;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with a 256-clock window.
// A second instance with a 4-bit edge counter shares the stimulus to show
// edge-count saturation.
module tb_pwm_duty_meter;

  localparam int PW = 24;
  localparam int WL = 8;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    pwm = 2'b00;

  logic [PW-1:0] duty0, duty1;
  logic [EW-1:0] edges0, edges1;
  logic [3:0]    stuck;
  logic          valid;

  logic [PW-1:0] e4_duty0, e4_duty1;
  logic [3:0]    e4_edges0, e4_edges1;
  logic [3:0]    e4_stuck;
  logic          e4_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int nvalid  = 0;
  int mode    = 0;      // 0: constant, 1: square (ch0 2/4, ch1 1/8), 2: ch0 toggles
  int ph      = 0;
  logic [1:0] const_val = 2'b00;
  int k;

  always #5 clk = ~clk;

  pwm_duty_meter #(
    .C_PWM_WIDTH  (PW),
    .C_WINDOW_LOG2(WL),
    .C_EDGE_WIDTH (EW)
  ) dut (
    .pwm_clk_i   (clk),
    .pwm_rst_n_i (rst_n),
    .enable_i    (enable),
    .PWM         (pwm),
    .duty0_o     (duty0),
    .duty1_o     (duty1),
    .edges0_o    (edges0),
    .edges1_o    (edges1),
    .stuck_o     (stuck),
    .duty_valid_o(valid)
  );

  pwm_duty_meter #(
    .C_PWM_WIDTH  (PW),
    .C_WINDOW_LOG2(WL),
    .C_EDGE_WIDTH (4)
  ) dut_e4 (
    .pwm_clk_i   (clk),
    .pwm_rst_n_i (rst_n),
    .enable_i    (enable),
    .PWM         (pwm),
    .duty0_o     (e4_duty0),
    .duty1_o     (e4_duty1),
    .edges0_o    (e4_edges0),
    .edges1_o    (e4_edges1),
    .stuck_o     (e4_stuck),
    .duty_valid_o(e4_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // One clock: drive the pattern for this phase, then sample 1 unit after the edge.
  task automatic step();
    case (mode)
      1:       pwm = {((ph % 8) == 0) ? 1'b1 : 1'b0, ((ph % 4) < 2) ? 1'b1 : 1'b0};
      2:       pwm = {1'b0, ph[0]};
      default: pwm = const_val;
    endcase
    @(posedge clk);
    #1;
    ph++;
    if (valid) nvalid++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until a result pulse is seen; cnt is the number of clocks taken.
  task automatic wait_valid(input string tag, input int max, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < max) begin
      step();
      cnt++;
      seen = valid;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'(cnt), 32'(max + 1));
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 rst_n = 1'b0;
    run(3);
    check_eq("rst_duty0",  32'(duty0),  32'h0);
    check_eq("rst_duty1",  32'(duty1),  32'h0);
    check_eq("rst_edges0", 32'(edges0), 32'h0);
    check_eq("rst_stuck",  32'(stuck),  32'h0);
    check_eq("rst_valid",  32'(valid),  32'h0);
    rst_n = 1'b1;

    // ---------------- ch0 held high, ch1 held low ----------------
    mode = 0;
    const_val = 2'b01;
    run(6);
    enable = 1'b1;
    nvalid = 0;
    wait_valid("const_w1", 300, k);
    check_eq("const_first_pulse_clk", 32'(k), 32'd257);
    wait_valid("const_w2", 300, k);
    check_eq("const_pulse_spacing", 32'(k), 32'd256);
    run(600 - 513);
    check_eq("const_pulses", 32'(nvalid), 32'd2);
    check_eq("const_duty0",  32'(duty0),  32'hFF_FFFF);
    check_eq("const_duty1",  32'(duty1),  32'h0);
    check_eq("const_stuck",  32'(stuck),  32'b0110);
    check_eq("const_edges0", 32'(edges0), 32'h0);
    check_eq("const_edges1", 32'(edges1), 32'h0);

    // ---------------- square waves on both channels ----------------
    mode = 1;
    ph = 0;
    wait_valid("sq_w1", 300, k);
    wait_valid("sq_w2", 300, k);
    wait_valid("sq_w3", 300, k);
    check_eq("sq_duty0",     32'(duty0),     32'h80_0000);
    check_eq("sq_edges0",    32'(edges0),    32'd64);
    check_eq("sq_duty1",     32'(duty1),     32'h20_0000);
    check_eq("sq_edges1",    32'(edges1),    32'd32);
    check_eq("sq_stuck",     32'(stuck),     32'b0000);
    check_eq("sq_e4_edges0", 32'(e4_edges0), 32'd15);
    check_eq("sq_e4_edges1", 32'(e4_edges1), 32'd15);

    // ---------------- enable drop at wc=100 ----------------
    run(100);
    enable = 1'b0;
    mode = 0;
    const_val = 2'b10;
    nvalid = 0;
    run(10);
    check_eq("drop_no_pulse", 32'(nvalid), 32'd0);
    check_eq("drop_held_duty0",  32'(duty0),  32'h80_0000);
    check_eq("drop_held_edges1", 32'(edges1), 32'd32);
    enable = 1'b1;
    wait_valid("reen", 300, k);
    check_eq("reen_pulse_clk", 32'(k), 32'd257);
    check_eq("reen_pulses",    32'(nvalid), 32'd1);
    check_eq("reen_duty0",  32'(duty0),  32'h0);
    check_eq("reen_duty1",  32'(duty1),  32'hFF_FFFF);
    check_eq("reen_edges1", 32'(edges1), 32'h0);
    check_eq("reen_stuck",  32'(stuck),  32'b1001);

    // ---------------- asynchronous reset mid-window ----------------
    run(50);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_duty1", 32'(duty1), 32'h0);
    check_eq("arst_stuck", 32'(stuck), 32'h0);
    check_eq("arst_valid", 32'(valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nvalid = 0;
    wait_valid("arst_restart", 400, k);
    check_eq("arst_restart_clk", 32'(k), 32'd259);
    check_eq("arst_duty1_after",  32'(duty1),  32'hFF_0000);
    check_eq("arst_edges1_after", 32'(edges1), 32'd1);
    check_eq("arst_stuck_after",  32'(stuck),  32'b0001);

    // ---------------- ch0 toggling every clock ----------------
    mode = 2;
    ph = 0;
    wait_valid("tog_w1", 300, k);
    wait_valid("tog_w2", 300, k);
    wait_valid("tog_w3", 300, k);
    check_eq("tog_duty0",     32'(duty0),     32'h80_0000);
    check_eq("tog_edges0",    32'(edges0),    32'd128);
    check_eq("tog_duty1",     32'(duty1),     32'h0);
    check_eq("tog_stuck",     32'(stuck),     32'b0100);
    check_eq("tog_e4_edges0", 32'(e4_edges0), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
